alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the result data width.
REQ-002 SHALL have parameter CNTW, default 16, the statistics counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream compare unit presents a result.
REQ-006 SHALL have port in_ready, output, 1, stage can accept a result this cycle.
REQ-007 SHALL have port in_result, input, WIDTH, compare unit result word (all-ones or zero for compare ops).
REQ-008 SHALL have port in_flag, input, 1, upstream zero flag (1 when in_result is zero).
REQ-009 SHALL have port out_valid, output, 1, stored result available downstream.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the head entry.
REQ-011 SHALL have port out_result, output, WIDTH, head entry result.
REQ-012 SHALL have port out_zero, output, 1, head entry zero flag, recomputed locally.
REQ-013 SHALL have port out_neg, output, 1, head entry MSB.
REQ-014 SHALL have port clr_stats, input, 1, synchronous clear of statistics and sticky error.
REQ-015 SHALL have port true_cnt, output, CNTW, count of accepted nonzero results.
REQ-016 SHALL have port flag_err, output, 1, sticky: an accepted in_flag disagreed with in_result.

Function
REQ-017 SHALL implement a 2-entry FIFO: entry = {result, zero, neg}; write/read pointers 1 bit, occupancy 0..2.
REQ-018 SHALL accept on (in_valid && in_ready); SHALL pop on (out_valid && out_ready).
REQ-019 SHALL drive in_ready = (occupancy < 2), from registered state only, never combinationally from out_ready.
REQ-020 SHALL drive out_valid = (occupancy > 0); out_result/out_zero/out_neg from head entry, stable while out_valid && !out_ready.
REQ-021 SHALL have latency 1 cycle: a result accepted at edge N is visible with out_valid high after edge N; no combinational bypass.
REQ-022 SHALL compute stored zero = (in_result == 0), ignoring in_flag; neg = in_result[WIDTH-1].
REQ-023 Occupancy 1 with simultaneous accept and pop: occupancy stays 1, new entry becomes head on the next cycle.
REQ-024 Occupancy 2: in_ready=0; a pop that cycle frees a slot, accept possible the following cycle only.
REQ-025 Occupancy 0: out_ready ignored, no pointer change.
REQ-026 SHALL increment true_cnt on each accept with in_result != 0; SHALL saturate at all-ones (no wrap).
REQ-027 SHALL set flag_err on an accept where in_flag != (in_result == 0); held until clr_stats or reset.
REQ-028 clr_stats SHALL zero true_cnt and flag_err next edge; an accept in the same cycle SHALL NOT update them (clear wins).
REQ-029 Upstream data while in_ready=0 SHALL be ignored and SHALL NOT affect statistics.

Reset
REQ-030 On rst_n low, asynchronously: occupancy 0, pointers 0, out_valid=0, in_ready=0 during reset, true_cnt=0, flag_err=0, out_result/out_zero/out_neg=0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-032 Reset mid-transfer SHALL discard all stored entries; no output after release until a new accept.

Verification
REQ-033 Single transfer: in_result=FFFFFFFF, in_flag=0, out_ready=1 -> out_valid one cycle later, out_result=FFFFFFFF, out_zero=0, out_neg=1, true_cnt=1.
REQ-034 Backpressure: out_ready=0, push 00000000 then FFFFFFFF -> in_ready=0 after 2nd accept; third push ignored; releasing out_ready yields 00000000 then FFFFFFFF in order, true_cnt=1.
REQ-035 Flag mismatch: in_result=00000000, in_flag=0 -> flag_err=1 and stays 1; clr_stats pulse -> flag_err=0, true_cnt=0.
REQ-036 Saturation: CNTW=4, accept 20 nonzero results -> true_cnt=0xF, not wrapped.
REQ-037 Streaming: in_valid=1, out_ready=1 continuously with alternating 0/FFFFFFFF -> one output per cycle after first, no drops, occupancy <= 1.
REQ-038 Async reset: assert rst_n low with 2 entries stored, between clock edges -> out_valid=0 immediately; after release in_ready=1, true_cnt=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Result stage behind the compare unit: a 2-entry FIFO of {result, zero, neg}
// plus a saturating nonzero-result counter and a sticky upstream-flag error.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             clr_stats,
  output logic [CNTW-1:0]  true_cnt,
  output logic             flag_err
);

  logic [WIDTH-1:0] res_q [2];
  logic [WIDTH-1:0] res_d [2];
  logic [1:0]       zero_q, zero_d;
  logic [1:0]       neg_q, neg_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push, pop, in_zero;

  always_comb begin
    push    = in_valid && in_ready_q;
    pop     = (occ_q != 2'd0) && out_ready;
    in_zero = (in_result == '0);

    res_d  = res_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (push) begin
      res_d[wr_ptr_q]  = in_result;
      zero_d[wr_ptr_q] = in_zero;
      neg_d[wr_ptr_q]  = in_result[WIDTH-1];
    end

    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    // Ready is registered from next occupancy so it never depends on out_ready
    // combinationally; it also stays low until the first edge after reset.
    in_ready_d = (occ_d != 2'd2);

    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_stats) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (push) begin
      if (!in_zero && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      if (in_flag != in_zero) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q      <= '{default: '0};
      zero_q     <= '0;
      neg_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      res_q      <= res_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (occ_q != 2'd0);
  assign out_result = res_q[rd_ptr_q];
  assign out_zero   = zero_q[rd_ptr_q];
  assign out_neg    = neg_q[rd_ptr_q];
  assign true_cnt   = cnt_q;
  assign flag_err   = err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, streaming/saturation/reset
// sequences and randomized traffic, all checked against a queue-based model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_flag = 1'b0, out_ready = 1'b0, clr_stats = 1'b0;
  logic [31:0] in_result = '0;

  logic        in_ready, out_valid, out_zero, out_neg, flag_err;
  logic [31:0] out_result;
  logic [15:0] true_cnt;
  logic        in_ready4, out_valid4, out_zero4, out_neg4, flag_err4;
  logic [31:0] out_result4;
  logic [3:0]  true_cnt4;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flag(in_flag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_neg(out_neg), .clr_stats(clr_stats), .true_cnt(true_cnt),
    .flag_err(flag_err)
  );

  alu_result_stage #(.WIDTH(32), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_result(in_result), .in_flag(in_flag), .out_valid(out_valid4),
    .out_ready(out_ready), .out_result(out_result4), .out_zero(out_zero4),
    .out_neg(out_neg4), .clr_stats(clr_stats), .true_cnt(true_cnt4),
    .flag_err(flag_err4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as a plain queue of result words.
  logic [31:0] mq[$];
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  bit          m_armed = 1'b0;

  typedef struct {
    logic        iv;
    logic [31:0] r;
    logic        f;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_z;
    logic        e_n;
    logic        e_ir;
    int          e_cnt;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [31:0] r, logic f, logic ordy, logic clr,
                              logic ov, logic [31:0] res, logic z, logic n, logic ir,
                              int cnt, logic err);
    vec_t v;
    v.iv = iv; v.r = r; v.f = f; v.ordy = ordy; v.clr = clr;
    v.e_ov = ov; v.e_res = res; v.e_z = z; v.e_n = n; v.e_ir = ir;
    v.e_cnt = cnt; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_check();
    logic [31:0] h;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_valid4", out_valid4, mq.size() > 0);
    chk("in_ready", in_ready, m_armed && (mq.size() < 2));
    chk("in_ready4", in_ready4, m_armed && (mq.size() < 2));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_result", out_result, h);
      chk("out_zero", out_zero, h == 32'd0);
      chk("out_neg", out_neg, h[31]);
      chk("out_result4", out_result4, h);
    end
    chk("true_cnt", true_cnt, sat(m_cnt, 65535));
    chk("true_cnt4", true_cnt4, sat(m_cnt, 15));
    chk("flag_err", flag_err, m_err);
    chk("flag_err4", flag_err4, m_err);
  endtask

  task automatic step(input logic iv, input logic [31:0] r, input logic f,
                      input logic ordy, input logic clr);
    bit acc, pop;
    in_valid = iv; in_result = r; in_flag = f; out_ready = ordy; clr_stats = clr;
    acc = iv && m_armed && rst_n && (mq.size() < 2);
    pop = rst_n && (mq.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(r);
    if (clr && rst_n) begin
      m_cnt = 0;
      m_err = 1'b0;
    end else if (acc) begin
      if (r != 32'd0) m_cnt++;
      if (f != (r == 32'd0)) m_err = 1'b1;
    end
    if (rst_n) m_armed = 1'b1;
    model_check();
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_err = 1'b0;
    m_armed = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] r;
    logic        f;

    tbl[0]  = mk(1, 32'hFFFFFFFF, 0, 1, 0,  1, 32'hFFFFFFFF, 0, 1, 1, 1, 0);
    tbl[1]  = mk(0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 0, 1, 1, 0);
    tbl[2]  = mk(1, 32'h0,        1, 0, 0,  1, 32'h0,        1, 0, 1, 1, 0);
    tbl[3]  = mk(1, 32'hFFFFFFFF, 0, 0, 0,  1, 32'h0,        1, 0, 0, 2, 0);
    tbl[4]  = mk(1, 32'h12345678, 0, 0, 0,  1, 32'h0,        1, 0, 0, 2, 0);
    tbl[5]  = mk(0, 32'h0,        0, 1, 0,  1, 32'hFFFFFFFF, 0, 1, 1, 2, 0);
    tbl[6]  = mk(0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 0, 1, 2, 0);
    tbl[7]  = mk(1, 32'h0,        0, 0, 0,  1, 32'h0,        1, 0, 1, 2, 1);
    tbl[8]  = mk(0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 0, 1, 2, 1);
    tbl[9]  = mk(0, 32'h0,        0, 0, 1,  0, 32'h0,        0, 0, 1, 0, 0);
    tbl[10] = mk(1, 32'h5,        1, 0, 1,  1, 32'h5,        0, 0, 1, 0, 0);
    tbl[11] = mk(1, 32'h80000000, 0, 1, 0,  1, 32'h80000000, 0, 1, 1, 1, 0);
    tbl[12] = mk(0, 32'h0,        0, 1, 0,  0, 32'h0,        0, 0, 1, 1, 0);

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_neg", out_neg, 1'b0);
    chk("rst_true_cnt", true_cnt, 16'h0);
    chk("rst_flag_err", flag_err, 1'b0);
    #2 rst_n = 1'b1;
    chk("pre_edge_in_ready", in_ready, 1'b0);
    step(0, 32'h0, 0, 0, 0);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].iv, tbl[i].r, tbl[i].f, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ir);
      if (tbl[i].e_ov) begin
        chk($sformatf("tbl%0d_out_result", i), out_result, tbl[i].e_res);
        chk($sformatf("tbl%0d_out_zero", i), out_zero, tbl[i].e_z);
        chk($sformatf("tbl%0d_out_neg", i), out_neg, tbl[i].e_n);
      end
      chk($sformatf("tbl%0d_true_cnt", i), true_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_flag_err", i), flag_err, tbl[i].e_err);
    end

    // Streaming alternating 0 / all-ones: one output per cycle, never full
    for (int i = 0; i < 40; i++) begin
      r = (i % 2 == 0) ? 32'h0 : 32'hFFFFFFFF;
      step(1, r, r == 32'h0, 1, 0);
      chk("stream_out_valid", out_valid, 1'b1);
      chk("stream_out_result", out_result, r);
      chk("stream_in_ready", in_ready, 1'b1);
    end
    step(0, 32'h0, 0, 1, 0);

    // Counter saturation: 20 nonzero accepts
    step(0, 32'h0, 0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, $urandom | 32'h1, 0, 1, 0);
    chk("sat_true_cnt4", true_cnt4, 4'hF);
    chk("sat_true_cnt16", true_cnt, 16'd20);
    step(0, 32'h0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 32'h0;
        1: r = 32'hFFFFFFFF;
        default: r = $urandom;
      endcase
      f = (r == 32'h0) ^ ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 3) != 0, r, f, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset with two entries stored
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 1, 0);
    step(1, 32'hAAAA5555, 0, 0, 0);
    step(1, 32'h0, 1, 0, 0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_in_ready", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_out_result", out_result, 32'h0);
    chk("arst_true_cnt", true_cnt, 16'h0);
    chk("arst_flag_err", flag_err, 1'b0);
    model_check();
    #1 rst_n = 1'b1;
    step(0, 32'h0, 0, 1, 0);
    chk("rel_in_ready", in_ready, 1'b1);
    chk("rel_out_valid", out_valid, 1'b0);
    chk("rel_true_cnt", true_cnt, 16'h0);
    step(1, 32'h00000007, 0, 0, 0);
    chk("rel_push_out_result", out_result, 32'h7);
    step(0, 32'h0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
